// File: rtl/wb_dual_retire.sv
// Dual-issue write-back stage: registers the two-slot memory bus, commits both slots to the
// register file and HI/LO in one cycle, and serializes retirements through a FIFO onto the debug trace.
module wb_dual_retire #(
   parameter int FIFO_DEPTH   = 4,
   parameter int MEM_TO_WB_WD = 136,
   parameter int HILO_WD      = 66
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      flush,
   input  logic [5:0]                stall,
   input  logic [2*MEM_TO_WB_WD-1:0] mem_to_wb_bus,
   output logic [75:0]               wb_to_rf_bus,
   output logic [31:0]               hi_o,
   output logic [31:0]               lo_o,
   output logic                      stallreq_wb,
   output logic [31:0]               debug_wb_pc,
   output logic [3:0]                debug_wb_rf_wen,
   output logic [4:0]                debug_wb_rf_wnum,
   output logic [31:0]               debug_wb_rf_wdata
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = 70;

   logic [2*MEM_TO_WB_WD-1:0] r_stage;
   logic                      r_fresh;
   logic [31:0]               r_hi;
   logic [31:0]               r_lo;
   logic [ENT_W-1:0]          r_fifo [FIFO_DEPTH];
   logic [PTR_W-1:0]          r_wptr;
   logic [PTR_W-1:0]          r_rptr;
   logic [CNT_W-1:0]          r_count;
   logic [31:0]               r_dbg_pc;
   logic [3:0]                r_dbg_wen;
   logic [4:0]                r_dbg_wnum;
   logic [31:0]               r_dbg_wdata;

   logic [MEM_TO_WB_WD-1:0] w_slot1, w_slot2;
   logic [HILO_WD-1:0]      w_hilo1, w_hilo2;
   logic [31:0]             w_pc1, w_pc2, w_wdata1, w_wdata2;
   logic [4:0]              w_waddr1, w_waddr2;
   logic                    w_we1, w_we2;
   logic                    w_push1, w_push2;
   logic [1:0]              w_npush;
   logic                    w_pop;
   logic [CNT_W-1:0]        w_count_next;
   logic [PTR_W-1:0]        w_wptr2;
   logic [ENT_W-1:0]        w_ent1, w_ent2, w_rd;
   logic                    w_unused_stall;

   assign w_unused_stall = ^stall[4:0];

   assign w_slot1  = r_stage[MEM_TO_WB_WD-1:0];
   assign w_slot2  = r_stage[2*MEM_TO_WB_WD-1:MEM_TO_WB_WD];
   assign w_hilo1  = w_slot1[MEM_TO_WB_WD-1 -: HILO_WD];
   assign w_hilo2  = w_slot2[MEM_TO_WB_WD-1 -: HILO_WD];
   assign w_pc1    = w_slot1[69:38];
   assign w_pc2    = w_slot2[69:38];
   assign w_we1    = w_slot1[37];
   assign w_we2    = w_slot2[37];
   assign w_waddr1 = w_slot1[36:32];
   assign w_waddr2 = w_slot2[36:32];
   assign w_wdata1 = w_slot1[31:0];
   assign w_wdata2 = w_slot2[31:0];

   // A slot retires only in the single cycle after capture; a zero PC marks a bubble.
   assign w_push1 = r_fresh & (w_pc1 != 32'd0);
   assign w_push2 = r_fresh & (w_pc2 != 32'd0);

   assign wb_to_rf_bus = {w_push2 & w_we2, w_waddr2, w_wdata2,
                          w_push1 & w_we1, w_waddr1, w_wdata1};

   assign w_ent1 = {w_pc1, w_we1 & (w_waddr1 != 5'd0), w_waddr1, w_wdata1};
   assign w_ent2 = {w_pc2, w_we2 & (w_waddr2 != 5'd0), w_waddr2, w_wdata2};

   assign w_npush      = {1'b0, w_push1} + {1'b0, w_push2};
   assign w_pop        = (r_count != '0);
   assign w_count_next = r_count + CNT_W'(w_npush) - CNT_W'(w_pop);
   assign w_wptr2      = r_wptr + PTR_W'(w_push1);
   assign w_rd         = r_fifo[r_rptr];

   // Holding upstream while two entries could still be missing keeps room for the next dual retire.
   assign stallreq_wb = (w_count_next > CNT_W'(FIFO_DEPTH - 2));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_stage <= '0;
         r_fresh <= 1'b0;
      end else if (flush) begin
         r_stage <= '0;
         r_fresh <= 1'b0;
      end else if (!stall[5]) begin
         r_stage <= mem_to_wb_bus;
         r_fresh <= 1'b1;
      end else begin
         r_fresh <= 1'b0;
      end
   end

   // i2 is applied after i1 so it wins a same-register conflict.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_hi <= '0;
         r_lo <= '0;
      end else begin
         if (w_push1 & w_hilo1[65]) r_hi <= w_hilo1[63:32];
         if (w_push1 & w_hilo1[64]) r_lo <= w_hilo1[31:0];
         if (w_push2 & w_hilo2[65]) r_hi <= w_hilo2[63:32];
         if (w_push2 & w_hilo2[64]) r_lo <= w_hilo2[31:0];
      end
   end

   always_ff @(posedge clk) begin
      if (w_push1) r_fifo[r_wptr]  <= w_ent1;
      if (w_push2) r_fifo[w_wptr2] <= w_ent2;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         r_wptr  <= r_wptr + PTR_W'(w_npush);
         r_rptr  <= r_rptr + PTR_W'(w_pop);
         r_count <= w_count_next;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_dbg_pc    <= '0;
         r_dbg_wen   <= '0;
         r_dbg_wnum  <= '0;
         r_dbg_wdata <= '0;
      end else if (w_pop) begin
         r_dbg_pc    <= w_rd[69:38];
         r_dbg_wen   <= {4{w_rd[37]}};
         r_dbg_wnum  <= w_rd[36:32];
         r_dbg_wdata <= w_rd[31:0];
      end else begin
         r_dbg_pc    <= '0;
         r_dbg_wen   <= '0;
         r_dbg_wnum  <= '0;
         r_dbg_wdata <= '0;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
      w_count_next <= CNT_W'(FIFO_DEPTH));

   assign hi_o              = r_hi;
   assign lo_o              = r_lo;
   assign debug_wb_pc       = r_dbg_pc;
   assign debug_wb_rf_wen   = r_dbg_wen;
   assign debug_wb_rf_wnum  = r_dbg_wnum;
   assign debug_wb_rf_wdata = r_dbg_wdata;

endmodule

// File: tb/tb_wb_dual_retire.sv
// Scoreboard bench for wb_dual_retire: the stimulus records expected RF writes, HI/LO values and
// trace entries in program order; a negedge monitor compares them with what the stage presents.
module tb_wb_dual_retire;

   logic         clk = 1'b0;
   logic         resetn = 1'b1;
   logic         flush = 1'b0;
   logic [5:0]   stall = '0;
   logic [271:0] mem_to_wb_bus = '0;
   logic [75:0]  wb_to_rf_bus;
   logic [31:0]  hi_o, lo_o;
   logic         stallreq_wb;
   logic [31:0]  debug_wb_pc;
   logic [3:0]   debug_wb_rf_wen;
   logic [4:0]   debug_wb_rf_wnum;
   logic [31:0]  debug_wb_rf_wdata;

   wb_dual_retire #(.FIFO_DEPTH(4), .MEM_TO_WB_WD(136), .HILO_WD(66)) dut (
      .clk(clk), .resetn(resetn), .flush(flush), .stall(stall),
      .mem_to_wb_bus(mem_to_wb_bus), .wb_to_rf_bus(wb_to_rf_bus),
      .hi_o(hi_o), .lo_o(lo_o), .stallreq_wb(stallreq_wb),
      .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
      .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
   );

   typedef struct {int cyc; logic [75:0] bus;} rf_exp_t;
   typedef struct {int cyc; logic [31:0] hi; logic [31:0] lo;} hl_exp_t;
   typedef struct {logic [31:0] pc; logic [3:0] wen; logic [4:0] wnum; logic [31:0] wdata;} tr_t;

   rf_exp_t rf_q[$];
   hl_exp_t hl_q[$];
   tr_t     tr_q[$];
   rf_exp_t m_rf;
   hl_exp_t m_hl;
   tr_t     m_tr;

   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          seen_stallreq = 1'b0;
   logic [31:0] ref_hi = '0, ref_lo = '0;
   logic [31:0] exp_hi = '0, exp_lo = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got running, want finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [75:0] act, input logic [75:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, req);
      end
   endtask

   function automatic logic [135:0] mk_slot(input logic [31:0] pc, input logic we,
                                            input logic [4:0] wa, input logic [31:0] wd,
                                            input logic hwe, input logic lwe,
                                            input logic [31:0] hd, input logic [31:0] ld);
      return {hwe, lwe, hd, ld, pc, we, wa, wd};
   endfunction

   function automatic logic [135:0] rand_slot(input bit may_bubble);
      logic [31:0] pc;
      if (may_bubble && ($urandom_range(0, 4) == 0)) return '0;
      pc = $urandom & 32'hFFFF_FFFC;
      if (pc == 32'd0) pc = 32'h4;
      return mk_slot(pc, 1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom, $urandom);
   endfunction

   // Reference: a pair accepted at edge n is visible on the RF bus during cycle n, changes HI/LO
   // from cycle n+1, and contributes valid slots to the trace in program order.
   task automatic model_accept(input logic [271:0] bus, input int n);
      logic [135:0] s [2];
      logic [75:0]  rfe;
      logic         valid;
      s[0] = bus[135:0];
      s[1] = bus[271:136];
      rfe  = '0;
      for (int k = 0; k < 2; k++) begin
         valid = (s[k][69:38] != 32'd0);
         rfe[k*38 +: 38] = {valid & s[k][37], s[k][36:32], s[k][31:0]};
         if (valid) begin
            if (s[k][135]) ref_hi = s[k][133:102];
            if (s[k][134]) ref_lo = s[k][101:70];
            tr_q.push_back('{s[k][69:38], (s[k][37] && s[k][36:32] != 5'd0) ? 4'hF : 4'h0,
                             s[k][36:32], s[k][31:0]});
         end
      end
      rf_q.push_back('{n, rfe});
      hl_q.push_back('{n + 1, ref_hi, ref_lo});
   endtask

   always @(negedge clk) begin
      if (!resetn) begin
         rf_q.delete();
         hl_q.delete();
         tr_q.delete();
         exp_hi = '0;
         exp_lo = '0;
      end else begin
         if (stallreq_wb) seen_stallreq = 1'b1;
         if (rf_q.size() > 0 && rf_q[0].cyc == cyc) begin
            m_rf = rf_q.pop_front();
            check("rf_bus", wb_to_rf_bus, m_rf.bus);
         end else begin
            check("rf_no_write", {74'd0, wb_to_rf_bus[75], wb_to_rf_bus[37]}, 76'd0);
         end
         while (hl_q.size() > 0 && hl_q[0].cyc <= cyc) begin
            m_hl   = hl_q.pop_front();
            exp_hi = m_hl.hi;
            exp_lo = m_hl.lo;
         end
         check("hi", 76'(hi_o), 76'(exp_hi));
         check("lo", 76'(lo_o), 76'(exp_lo));
         if (debug_wb_pc != 32'd0) begin
            if (tr_q.size() == 0) begin
               check("trace_extra", 76'(debug_wb_pc), 76'd0);
            end else begin
               m_tr = tr_q.pop_front();
               check("trace", 76'({debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata}),
                     76'({m_tr.pc, m_tr.wen, m_tr.wnum, m_tr.wdata}));
            end
         end else begin
            check("trace_idle", 76'({debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata}), 76'd0);
         end
      end
   end

   task automatic idle();
      @(posedge clk); #1;
      flush = 1'b0;
      stall = '0;
      stall[5] = stallreq_wb;
      mem_to_wb_bus = '0;
   endtask

   task automatic hold();
      @(posedge clk); #1;
      flush = 1'b0;
      stall = {1'b1, 5'($urandom)};
      mem_to_wb_bus = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic do_flush();
      @(posedge clk); #1;
      flush = 1'b1;
      stall = 6'($urandom);
      mem_to_wb_bus = {rand_slot(0), rand_slot(0)};
   endtask

   task automatic send(input logic [271:0] bus, input bit rnd);
      int guard;
      bit done;
      guard = 0;
      done  = 1'b0;
      while (!done && guard < 40) begin
         @(posedge clk); #1;
         flush = 1'b0;
         stall = {1'b0, 5'($urandom)};
         stall[5] = stallreq_wb | (rnd && ($urandom_range(0, 3) == 0));
         mem_to_wb_bus = bus;
         if (!stall[5]) begin
            done = 1'b1;
            model_accept(bus, cyc + 1);
         end
         guard++;
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: got stalled for %0d cycles, want acceptance", guard);
      end
   endtask

   logic [271:0] pa, pb;

   initial begin
      #1 resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rf", wb_to_rf_bus, 76'd0);
      check("rst_dbg", 76'({debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata}), 76'd0);
      check("rst_hilo", 76'({hi_o, lo_o}), 76'd0);
      check("rst_stallreq", 76'(stallreq_wb), 76'd0);
      resetn = 1'b1;

      // Reset in the middle of a drain with three entries queued.
      pa = {mk_slot(32'h1000_0004, 1'b1, 5'd7, 32'hAA, 1'b0, 1'b1, 32'h0, 32'h77),
            mk_slot(32'h1000_0000, 1'b1, 5'd6, 32'h99, 1'b1, 1'b0, 32'h66, 32'h0)};
      pb = {rand_slot(0), rand_slot(0)};
      send(pa, 0);
      send(pb, 0);
      idle();
      @(posedge clk);
      @(negedge clk); #2;
      check("t1_pre_pc", 76'(debug_wb_pc), 76'(32'h1000_0000));
      resetn = 1'b0;
      #1;
      check("t1_rst_rf", wb_to_rf_bus, 76'd0);
      check("t1_rst_dbg", 76'({debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata}), 76'd0);
      check("t1_rst_hilo", 76'({hi_o, lo_o}), 76'd0);
      check("t1_rst_stallreq", 76'(stallreq_wb), 76'd0);
      ref_hi = '0;
      ref_lo = '0;
      @(posedge clk); #1;
      flush = 1'b0;
      stall = '0;
      mem_to_wb_bus = '0;
      @(posedge clk); #1;
      resetn = 1'b1;
      repeat (3) idle();
      check("t1_idle_dbg", 76'({debug_wb_pc, debug_wb_rf_wen}), 76'd0);
      check("t1_idle_stallreq", 76'(stallreq_wb), 76'd0);

      // Dual retire and trace latency.
      pa = {mk_slot(32'hBFC0_0004, 1'b1, 5'd3, 32'h22, 1'b0, 1'b0, 32'h0, 32'h0),
            mk_slot(32'hBFC0_0000, 1'b1, 5'd2, 32'h11, 1'b0, 1'b0, 32'h0, 32'h0)};
      send(pa, 0);
      idle();
      check("t2_rf", wb_to_rf_bus, {1'b1, 5'd3, 32'h22, 1'b1, 5'd2, 32'h11});
      idle();
      idle();
      check("t2_trace_i1", 76'({debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata}),
            76'({32'hBFC0_0000, 4'hF, 5'd2, 32'h11}));
      idle();
      check("t2_trace_i2", 76'({debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata}),
            76'({32'hBFC0_0004, 4'hF, 5'd3, 32'h22}));
      repeat (4) idle();

      // HI/LO: i2 overrides HI only.
      pa = {mk_slot(32'h0000_0104, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'd2, 32'd0),
            mk_slot(32'h0000_0100, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'd1, 32'd5)};
      send(pa, 0);
      idle();
      idle();
      check("t4_hi", 76'(hi_o), 76'd2);
      check("t4_lo", 76'(lo_o), 76'd5);
      repeat (4) idle();

      // Bubble in i1, r0 destination in i2.
      pa = {mk_slot(32'hBFC0_0010, 1'b1, 5'd0, 32'h7, 1'b0, 1'b0, 32'h0, 32'h0), 136'd0};
      send(pa, 0);
      idle();
      idle();
      idle();
      check("t6_trace", 76'({debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata}),
            76'({32'hBFC0_0010, 4'h0, 5'd0, 32'h7}));
      idle();
      check("t6_single", 76'(debug_wb_pc), 76'd0);
      repeat (3) idle();

      // Hold for three cycles, then flush.
      pa = {mk_slot(32'h0000_0204, 1'b1, 5'd6, 32'h66, 1'b0, 1'b0, 32'h0, 32'h0),
            mk_slot(32'h0000_0200, 1'b1, 5'd5, 32'h55, 1'b0, 1'b0, 32'h0, 32'h0)};
      send(pa, 0);
      hold();
      hold();
      hold();
      check("t5_held", wb_to_rf_bus, {1'b0, 5'd6, 32'h66, 1'b0, 5'd5, 32'h55});
      do_flush();
      idle();
      check("t5_cleared", wb_to_rf_bus, 76'd0);
      repeat (5) idle();

      // Eight back-to-back dual retires must raise the stall request.
      seen_stallreq = 1'b0;
      for (int i = 0; i < 8; i++) send({rand_slot(0), rand_slot(0)}, 0);
      repeat (2) idle();
      check("t3_stallreq_seen", 76'(seen_stallreq), 76'd1);

      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 9))
            0:       do_flush();
            1:       hold();
            default: send({rand_slot(1), rand_slot(1)}, 1);
         endcase
      end

      begin
         int g;
         g = 0;
         while ((tr_q.size() != 0 || rf_q.size() != 0) && g < 100) begin
            idle();
            g++;
         end
      end
      repeat (3) idle();
      check("drain_empty", 76'(tr_q.size()), 76'd0);
      check("drain_idle", 76'({debug_wb_pc, stallreq_wb}), 76'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
